// File: rtl/executor.sv
// executor: token-stream interpreter for assignment, "out" and "if" statements over three 8-bit variables
module executor #(
   parameter logic [7:0] NUM       = 8'h00,
   parameter logic [7:0] OUT       = 8'h01,
   parameter logic [7:0] VAR_A     = 8'h02,
   parameter logic [7:0] EQUAL     = 8'h03,
   parameter logic [7:0] VAR_B     = 8'h04,
   parameter logic [7:0] VAR_C     = 8'h05,
   parameter logic [7:0] IF        = 8'h06,
   parameter logic [7:0] BRACKET_A = 8'h07,
   parameter logic [7:0] BRACKET_B = 8'h08,
   parameter logic [7:0] PLUS      = 8'h09,
   parameter logic [7:0] MINUS     = 8'h0a,
   parameter logic [7:0] SEMICOLON = 8'h0b,
   parameter logic [7:0] EOF       = 8'h0c
)(
   input  logic        CLK,
   input  logic        RST,
   input  logic        I_VALID,
   input  logic [15:0] I_DATA,
   output logic        O_VALID,
   output logic [7:0]  O_DATA,
   output logic        DONE,
   output logic        ERROR
);
   typedef enum logic [2:0] {STMT, EQ, TERM, OP, LPAREN, SKIP, HALT, ERR} state_t;
   typedef enum logic [2:0] {D_A, D_B, D_C, D_OUT, D_IF} dest_t;
   localparam logic [1:0] LOAD = 2'd0, ADD = 2'd1, SUB = 2'd2;
   state_t state, state_nx;
   dest_t dest, dest_nx;
   logic [1:0] op, op_nx;
   logic [7:0] a, b, c, acc, acc_nx, operand, tag, val;
   logic is_var, is_term, emit, wr;
   assign tag = I_DATA[15:8];
   assign val = I_DATA[7:0];
   assign is_var = tag == VAR_A || tag == VAR_B || tag == VAR_C;
   assign is_term = is_var || tag == NUM;
   // variables are only written at ';', so operands always see pre-statement values
   assign operand = tag == VAR_A ? a : tag == VAR_B ? b : tag == VAR_C ? c : val;
   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= STMT;
         dest    <= D_A;
         op      <= LOAD;
         acc     <= '0;
         a       <= '0;
         b       <= '0;
         c       <= '0;
         O_VALID <= 1'b0;
         O_DATA  <= '0;
      end else begin
         state   <= state_nx;
         dest    <= dest_nx;
         op      <= op_nx;
         acc     <= acc_nx;
         a       <= (wr && dest == D_A) ? acc : a;
         b       <= (wr && dest == D_B) ? acc : b;
         c       <= (wr && dest == D_C) ? acc : c;
         O_VALID <= emit;
         O_DATA  <= emit ? acc : O_DATA;
      end
   end
   always_comb begin
      state_nx = state;
      dest_nx  = dest;
      op_nx    = op;
      acc_nx   = acc;
      if (I_VALID) begin
         case (state)
            STMT: begin
               if (is_var) begin
                  dest_nx  = tag == VAR_A ? D_A : tag == VAR_B ? D_B : D_C;
                  state_nx = EQ;
               end else if (tag == OUT) begin
                  dest_nx  = D_OUT;
                  op_nx    = LOAD;
                  state_nx = TERM;
               end else
                  state_nx = tag == IF ? LPAREN : tag == EOF ? HALT : ERR;
            end
            EQ: begin
               op_nx    = LOAD;
               state_nx = tag == EQUAL ? TERM : ERR;
            end
            LPAREN: begin
               dest_nx  = D_IF;
               op_nx    = LOAD;
               state_nx = tag == BRACKET_A ? TERM : ERR;
            end
            TERM: begin
               acc_nx   = op == ADD ? acc + operand : op == SUB ? acc - operand : operand;
               state_nx = is_term ? OP : ERR;
            end
            OP: begin
               if (tag == PLUS || tag == MINUS) begin
                  op_nx    = tag == PLUS ? ADD : SUB;
                  state_nx = TERM;
               end else if (tag == SEMICOLON && dest != D_IF)
                  state_nx = STMT;
               else if (tag == BRACKET_B && dest == D_IF)
                  state_nx = acc != 8'd0 ? STMT : SKIP;
               else
                  state_nx = ERR;
            end
            SKIP: state_nx = (tag == EOF || tag > EOF) ? ERR : tag == SEMICOLON ? STMT : SKIP;
            default: state_nx = state;
         endcase
      end
   end
   always_comb begin
      emit  = I_VALID && state == OP && tag == SEMICOLON && dest == D_OUT;
      wr    = I_VALID && state == OP && tag == SEMICOLON && (dest == D_A || dest == D_B || dest == D_C);
      DONE  = state == HALT;
      ERROR = state == ERR;
   end
endmodule

// File: tb/tb_executor.sv
// tb_executor: table vectors, hand-written timing sequences and random programs against an interpreter model
module tb_executor;
   localparam logic [7:0] T_NUM = 8'h00, T_OUT = 8'h01, T_A = 8'h02, T_EQ = 8'h03, T_B = 8'h04,
                          T_C = 8'h05, T_IF = 8'h06, T_LP = 8'h07, T_RP = 8'h08, T_PLUS = 8'h09,
                          T_MINUS = 8'h0a, T_SEMI = 8'h0b, T_EOF = 8'h0c;
   logic CLK = 0, RST = 0, I_VALID = 0;
   logic [15:0] I_DATA = '0;
   logic O_VALID, DONE, ERROR;
   logic [7:0] O_DATA;
   int n_chk = 0, n_fail = 0;
   logic [15:0] prog[$];
   logic [7:0] got[$];
   logic [7:0] m_out[$];
   logic [7:0] mv[3];
   int pos;
   bit m_err, m_done, m_end;
   typedef struct {
      string p;
      int np;
      logic [7:0] last;
      bit done;
      bit err;
   } vec_t;
   vec_t vt[18];

   executor dut (.CLK(CLK), .RST(RST), .I_VALID(I_VALID), .I_DATA(I_DATA),
                 .O_VALID(O_VALID), .O_DATA(O_DATA), .DONE(DONE), .ERROR(ERROR));

   always #5 CLK = ~CLK;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc(input logic v, input logic [15:0] d);
      I_VALID = v;
      I_DATA = d;
      @(posedge CLK);
      #1;
      if (O_VALID === 1'b1) got.push_back(O_DATA);
   endtask

   task automatic do_reset();
      RST = 1;
      cyc(0, 16'h0);
      RST = 0;
      got.delete();
   endtask

   task automatic run_prog(input bit gaps);
      do_reset();
      foreach (prog[i]) begin
         if (gaps) repeat ($urandom_range(0, 2)) cyc(0, 16'($urandom));
         cyc(1, prog[i]);
      end
      repeat (3) cyc(0, 16'h0);
   endtask

   function automatic logic [15:0] tok_of(string w);
      int h;
      case (w)
         "out": return {T_OUT, 8'h0};
         "a":   return {T_A, 8'h0};
         "b":   return {T_B, 8'h0};
         "c":   return {T_C, 8'h0};
         "=":   return {T_EQ, 8'h0};
         "if":  return {T_IF, 8'h0};
         "(":   return {T_LP, 8'h0};
         ")":   return {T_RP, 8'h0};
         "+":   return {T_PLUS, 8'h0};
         "-":   return {T_MINUS, 8'h0};
         ";":   return {T_SEMI, 8'h0};
         "EOF": return {T_EOF, 8'h0};
         default: begin
            if (w[0] == "#") begin
               h = w.substr(1, w.len() - 1).atohex();
               return {h[7:0], 8'h0};
            end
            h = w.atoi();
            return {T_NUM, h[7:0]};
         end
      endcase
   endfunction

   function automatic void tokenize(string s);
      int st = 0;
      prog.delete();
      for (int i = 0; i <= s.len(); i++) begin
         if (i == s.len() || s[i] == " ") begin
            if (i > st) prog.push_back(tok_of(s.substr(st, i - 1)));
            st = i + 1;
         end
      end
   endfunction

   function automatic void setv(int i, string p, int np, logic [7:0] last, bit d, bit e);
      vt[i].p = p;
      vt[i].np = np;
      vt[i].last = last;
      vt[i].done = d;
      vt[i].err = e;
   endfunction

   function automatic bit nxt(output logic [7:0] t, output logic [7:0] v);
      t = 0;
      v = 0;
      if (pos >= prog.size()) begin
         m_end = 1;
         return 0;
      end
      t = prog[pos][15:8];
      v = prog[pos][7:0];
      pos++;
      return 1;
   endfunction

   function automatic bit is_v(logic [7:0] t);
      return t == T_A || t == T_B || t == T_C;
   endfunction

   function automatic int vidx(logic [7:0] t);
      return t == T_A ? 0 : t == T_B ? 1 : 2;
   endfunction

   // evaluates a signed sum in plain integers, reduced mod 256 only at the end
   function automatic bit expr(output logic [7:0] r, output logic [7:0] stop_tag);
      int s = 0;
      int sign = 1;
      logic [7:0] t, v;
      r = 0;
      stop_tag = 0;
      while (1) begin
         if (!nxt(t, v)) return 0;
         if (t == T_NUM) s += sign * int'(v);
         else if (is_v(t)) s += sign * int'(mv[vidx(t)]);
         else begin
            m_err = 1;
            return 0;
         end
         if (!nxt(t, v)) return 0;
         if (t == T_PLUS) sign = 1;
         else if (t == T_MINUS) sign = -1;
         else begin
            r = s[7:0];
            stop_tag = t;
            return 1;
         end
      end
      return 0;
   endfunction

   function automatic void run_model();
      logic [7:0] t, v, r, st;
      int k;
      pos = 0;
      m_err = 0;
      m_done = 0;
      m_end = 0;
      mv = '{default: 8'h0};
      m_out.delete();
      while (!m_err && !m_done && !m_end) begin
         if (!nxt(t, v)) break;
         if (is_v(t)) begin
            k = vidx(t);
            if (nxt(t, v)) begin
               if (t != T_EQ) m_err = 1;
               else if (expr(r, st)) begin
                  if (st == T_SEMI) mv[k] = r;
                  else m_err = 1;
               end
            end
         end else if (t == T_OUT) begin
            if (expr(r, st)) begin
               if (st == T_SEMI) m_out.push_back(r);
               else m_err = 1;
            end
         end else if (t == T_IF) begin
            if (nxt(t, v)) begin
               if (t != T_LP) m_err = 1;
               else if (expr(r, st)) begin
                  if (st != T_RP) m_err = 1;
                  else if (r == 0) begin
                     while (nxt(t, v)) begin
                        if (t >= T_EOF) begin
                           m_err = 1;
                           break;
                        end
                        if (t == T_SEMI) break;
                     end
                  end
               end
            end
         end else if (t == T_EOF) m_done = 1;
         else m_err = 1;
      end
   endfunction

   function automatic void add(logic [7:0] t, logic [7:0] v);
      prog.push_back({t, v});
   endfunction

   function automatic void gen_expr(bit zero);
      int n;
      if (zero) begin
         add(T_NUM, 8'h0);
         return;
      end
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) begin
         if (i > 0) add($urandom_range(0, 1) ? T_PLUS : T_MINUS, 8'h0);
         case ($urandom_range(0, 4))
            0: add(T_A, 8'h0);
            1: add(T_B, 8'h0);
            2: add(T_C, 8'h0);
            default: add(T_NUM, 8'($urandom));
         endcase
      end
   endfunction

   function automatic void gen_prog();
      int n = $urandom_range(2, 7);
      prog.delete();
      for (int i = 0; i < n; i++) begin
         case ($urandom_range(0, 3))
            0: begin
               add($urandom_range(0, 2) == 0 ? T_A : $urandom_range(0, 1) ? T_B : T_C, 8'h0);
               add(T_EQ, 8'h0);
               gen_expr(0);
               add(T_SEMI, 8'h0);
            end
            1: begin
               add(T_OUT, 8'h0);
               gen_expr(0);
               add(T_SEMI, 8'h0);
            end
            default: begin
               add(T_IF, 8'h0);
               add(T_LP, 8'h0);
               gen_expr(1'($urandom_range(0, 1)));
               add(T_RP, 8'h0);
            end
         endcase
      end
      foreach (mv[i]) begin
         add(T_OUT, 8'h0);
         add(i == 0 ? T_A : i == 1 ? T_B : T_C, 8'h0);
         add(T_SEMI, 8'h0);
      end
      if ($urandom_range(0, 1)) begin
         add(T_EOF, 8'h0);
         add(T_OUT, 8'h0);
         add(T_NUM, 8'h01);
         add(T_SEMI, 8'h0);
      end
      if ($urandom_range(0, 3) == 0)
         prog[$urandom_range(0, prog.size() - 1)] = {8'($urandom_range(0, 33)), 8'($urandom)};
   endfunction

   initial begin
      setv(0,  "out 5 + 3 ;", 1, 8'h08, 0, 0);
      setv(1,  "a = 250 ; a = a + 10 ; out a ;", 1, 8'h04, 0, 0);
      setv(2,  "if ( 0 ) out 1 ; out 2 ;", 1, 8'h02, 0, 0);
      setv(3,  "if ( 1 - 1 + 3 ) if ( 0 ) out 7 ; out 9 ;", 1, 8'h09, 0, 0);
      setv(4,  "out 1 ; EOF out 4 ;", 1, 8'h01, 1, 0);
      setv(5,  "a + ;", 0, 8'h00, 0, 1);
      setv(6,  "out ) ;", 0, 8'h00, 0, 1);
      setv(7,  "#20", 0, 8'h00, 0, 1);
      setv(8,  "out 0 - 1 ;", 1, 8'hff, 0, 0);
      setv(9,  "out 255 + 2 ;", 1, 8'h01, 0, 0);
      setv(10, "if ( 2 ) out 3 ; EOF", 1, 8'h03, 1, 0);
      setv(11, "if ( 0 ) out 1 EOF", 0, 8'h00, 0, 1);
      setv(12, "out 1 ; out 2 ; #20 out 3 ;", 2, 8'h02, 0, 1);
      setv(13, "b = 7 ; c = b - 2 ; out c + b ;", 1, 8'h0c, 0, 0);
      setv(14, "out 3 ; EOF #20", 1, 8'h03, 1, 0);
      setv(15, "a = 3 ; if ( a ) a = a + a ; out a ;", 1, 8'h06, 0, 0);
      setv(16, "out 5 )", 0, 8'h00, 0, 1);
      setv(17, "if ( 4 ;", 0, 8'h00, 0, 1);

      foreach (vt[i]) begin
         tokenize(vt[i].p);
         run_prog(0);
         chk($sformatf("vec%0d pulses", i), got.size(), vt[i].np);
         if (vt[i].np > 0 && got.size() > 0)
            chk($sformatf("vec%0d out", i), got[got.size() - 1], vt[i].last);
         chk($sformatf("vec%0d done", i), DONE, vt[i].done);
         chk($sformatf("vec%0d error", i), ERROR, vt[i].err);
      end

      // reset clears everything after a halted run that printed a value
      tokenize("out 7 ; EOF");
      run_prog(0);
      RST = 1;
      cyc(0, 16'h0);
      RST = 0;
      chk("rst o_valid", O_VALID, 0);
      chk("rst o_data", O_DATA, 0);
      chk("rst done", DONE, 0);
      chk("rst error", ERROR, 0);

      // pulse lands exactly one cycle after ';' and DONE one cycle after EOF
      do_reset();
      cyc(1, {T_OUT, 8'h0});
      cyc(1, {T_NUM, 8'h01});
      chk("emit early", O_VALID, 0);
      cyc(1, {T_SEMI, 8'h0});
      chk("emit valid", O_VALID, 1);
      chk("emit data", O_DATA, 8'h01);
      cyc(1, {T_EOF, 8'h0});
      chk("emit one-shot", O_VALID, 0);
      chk("done after eof", DONE, 1);
      got.delete();
      cyc(1, {T_OUT, 8'h0});
      cyc(1, {T_NUM, 8'h04});
      cyc(1, {T_SEMI, 8'h0});
      cyc(0, 16'h0);
      chk("halt no pulse", got.size(), 0);
      chk("halt o_data held", O_DATA, 8'h01);

      // ERROR rises right after the offending '+'
      do_reset();
      cyc(1, {T_A, 8'h0});
      chk("err before", ERROR, 0);
      cyc(1, {T_PLUS, 8'h0});
      chk("err after plus", ERROR, 1);

      // pending emit still completes when the next token is illegal
      do_reset();
      cyc(1, {T_OUT, 8'h0});
      cyc(1, {T_NUM, 8'h04});
      cyc(1, {T_SEMI, 8'h0});
      cyc(1, {8'h20, 8'h0});
      chk("pending emit", got.size(), 1);
      chk("pending err", ERROR, 1);
      chk("pending o_data", O_DATA, 8'h04);

      // reset mid-statement wins over a simultaneous token
      tokenize("out 9 ; b = 6 ; b = 3 +");
      run_prog(0);
      chk("pre-rst o_data", O_DATA, 8'h09);
      RST = 1;
      cyc(1, {T_NUM, 8'h05});
      RST = 0;
      chk("midrst o_data", O_DATA, 0);
      chk("midrst error", ERROR, 0);
      got.delete();
      cyc(1, {T_OUT, 8'h0});
      cyc(1, {T_B, 8'h0});
      cyc(1, {T_SEMI, 8'h0});
      cyc(0, 16'h0);
      chk("midrst pulses", got.size(), 1);
      chk("midrst b", got.size() > 0 ? got[0] : 8'hxx, 8'h00);
      chk("midrst no err", ERROR, 0);

      for (int r = 0; r < 40; r++) begin
         gen_prog();
         run_model();
         run_prog(1);
         chk($sformatf("rnd%0d pulses", r), got.size(), m_out.size());
         for (int k = 0; k < got.size() && k < m_out.size(); k++)
            chk($sformatf("rnd%0d out%0d", r, k), got[k], m_out[k]);
         chk($sformatf("rnd%0d done", r), DONE, m_done);
         chk($sformatf("rnd%0d error", r), ERROR, m_err);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
